fetch_stage: RTL and testbench

Instruction fetch stage and IF/ID pipeline register for the pipelined RV32I core with caches.
- Holds the PC and issues one instruction-memory (I-cache) request at a time over a valid/ready handshake.
- Captures the returned instruction into the IF/ID register, which drives the decode stage; decode feeds instr[31:7] to the immediate extender.
- Handles decode stalls, using a one-entry skid buffer, and execute-stage redirects (taken branch/jump), including discarding stale in-flight responses.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/fetch_skid_buf.sv | 31 +++
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: the fetch FSM state encoding, reset and NOP
// constants, and the IF/ID payload record used by the fetch stage.
package riscv_pkg;

  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    FETCH,  // request pending issue
    WAIT,   // request accepted, response outstanding
    DROP    // response outstanding but already stale
  } fetch_state_t;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] instr;
  } if_id_t;

  // Empty IF/ID slot: no instruction, NOP presented to decode.
  function automatic if_id_t if_id_bubble();
    return '{valid: 1'b0, pc: '0, pc_plus4: '0, instr: NOP_INSTR};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for an instruction that returned while decode
// was stalled. Clear beats load, load beats drain.
module fetch_skid_buf
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   drain,
  input  logic   clear,
  input  if_id_t load_data,
  output logic   valid,
  output if_id_t data
);

  // Occupancy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     valid <= 1'b0;
    else if (clear) valid <= 1'b0;
    else if (load)  valid <= 1'b1;
    else if (drain) valid <= 1'b0;
  end

  // Payload capture.
  // NOTE: the payload has no reset; it is only ever read while valid is set,
  // and keeping it out of the reset tree keeps the flops plain enables.
  always_ff @(posedge clk) begin
    if (load) data <= load_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC/request FSM talking to the I-cache over a
// valid/ready handshake, plus the IF/ID register feeding decode. A skid
// buffer absorbs a response that lands during a decode stall, and execute
// redirects flush IF/ID and mark any in-flight response as stale.
module fetch_stage
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_d,
  input  logic                  redirect_e,
  input  logic [DATA_WIDTH-1:0] redirect_pc_e,
  output logic                  imem_req_valid,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  output logic [DATA_WIDTH-1:0] instr_d,
  output logic [DATA_WIDTH-1:0] pc_d,
  output logic [DATA_WIDTH-1:0] pc_plus4_d,
  output logic                  valid_d
);

  fetch_state_t          state, state_next;
  logic [DATA_WIDTH-1:0] pc, pc_next;
  if_id_t                if_id, if_id_next, fresh, skid_data;
  logic                  skid_valid, skid_load, skid_drain;
  logic                  handshake, resp_live;

  // A full skid blocks new requests so at most one instruction is ever parked.
  assign imem_req_valid = rst_n && (state == FETCH) && !skid_valid;
  assign imem_req_addr  = pc;
  assign handshake      = imem_req_valid && imem_req_ready;

  // In WAIT, pc still holds the address of the in-flight request.
  assign resp_live = (state == WAIT) && imem_resp_valid && !redirect_e;
  assign fresh     = '{valid: 1'b1, pc: pc, pc_plus4: pc + DATA_WIDTH'(4),
                       instr: imem_resp_data};

  // Next state and next PC; a redirect overrides the PC in every state.
  // NOTE: every combinational output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    unique case (state)
      FETCH: if (handshake) state_next = redirect_e ? DROP : WAIT;
      WAIT: begin
        if (imem_resp_valid) begin
          state_next = FETCH;
          if (!redirect_e) pc_next = pc + DATA_WIDTH'(4);
        end else if (redirect_e) begin
          state_next = DROP;
        end
      end
      DROP:    if (imem_resp_valid) state_next = FETCH;
      default: state_next = FETCH;
    endcase
    if (redirect_e) pc_next = {redirect_pc_e[DATA_WIDTH-1:2], 2'b00};
  end

  // IF/ID update: redirect flushes, stall holds (parking any new response),
  // otherwise the skid drains first, then a fresh response, else a bubble.
  always_comb begin
    if_id_next = if_id;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    if (redirect_e) begin
      if_id_next = if_id_bubble();
    end else if (stall_d) begin
      skid_load = resp_live;
    end else if (skid_valid) begin
      if_id_next = skid_data;
      skid_drain = 1'b1;
    end else if (resp_live) begin
      if_id_next = fresh;
    end else begin
      if_id_next = if_id_bubble();
    end
  end

  // State, PC and IF/ID registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
      if_id <= if_id_bubble();
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if_id <= if_id_next;
    end
  end

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .drain     (skid_drain),
    .clear     (redirect_e),
    .load_data (fresh),
    .valid     (skid_valid),
    .data      (skid_data)
  );

  assign valid_d    = if_id.valid;
  assign pc_d       = if_id.pc;
  assign pc_plus4_d = if_id.pc_plus4;
  assign instr_d    = if_id.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an I-cache model with programmable latency, a
// transaction-level reference model (queue of outstanding requests, queue of
// parked instructions), a per-cycle compare process and directed scenarios
// with hand-computed literal expectations.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_d, redirect_e;
  logic [31:0] redirect_pc_e;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d;

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_d         (stall_d),
    .redirect_e      (redirect_e),
    .redirect_pc_e   (redirect_pc_e),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_d         (instr_d),
    .pc_d            (pc_d),
    .pc_plus4_d      (pc_plus4_d),
    .valid_d         (valid_d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'h5A00_0000;
  endfunction

  // ---------------- I-cache model ----------------
  int          lat = 1;
  bit          c_busy = 0;
  int          c_cnt;
  logic [31:0] c_addr;
  int          accepted_at_8 = 0;

  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (c_busy && c_cnt == 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(c_addr);
        c_busy          = 0;
      end else begin
        imem_resp_valid = 1'b0;
        if (c_busy) c_cnt--;
      end
      #2;
      if (rst_n && imem_req_valid && imem_req_ready) begin
        c_busy = 1;
        c_cnt  = lat;
        c_addr = imem_req_addr;
        if (imem_req_addr == 32'h8) accepted_at_8++;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { bit v; logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        out_q[$];
  ent_t        held_q[$];
  ent_t        m_ifid;
  logic [31:0] m_pc;
  bit          m_got, m_req;
  ent_t        m_fresh;
  req_t        m_head;

  function automatic ent_t bubble();
    return '{1'b0, 32'h0, NOP};
  endfunction

  task automatic model_step();
    m_req = (out_q.size() == 0) && (held_q.size() == 0);
    m_got = 0;
    if (out_q.size() != 0 && imem_resp_valid) begin
      m_head = out_q.pop_front();
      if (!m_head.stale && !redirect_e) begin
        m_got   = 1;
        m_fresh = '{1'b1, m_head.addr, imem_resp_data};
        m_pc    = m_head.addr + 32'd4;
      end
    end
    if (m_req && imem_req_ready) out_q.push_back('{m_pc, 1'b0});
    if (redirect_e) begin
      foreach (out_q[i]) out_q[i].stale = 1;
      held_q.delete();
      m_ifid = bubble();
      m_pc   = {redirect_pc_e[31:2], 2'b00};
    end else if (stall_d) begin
      if (m_got) held_q.push_back(m_fresh);
    end else if (held_q.size() != 0) begin
      m_ifid = held_q.pop_front();
    end else if (m_got) begin
      m_ifid = m_fresh;
    end else begin
      m_ifid = bubble();
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        out_q.delete();
        held_q.delete();
        m_ifid = bubble();
        m_pc   = 32'h0;
      end else begin
        model_step();
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && !done) begin
        check("req_valid", imem_req_valid, (out_q.size() == 0 && held_q.size() == 0));
        if (out_q.size() == 0 && held_q.size() == 0) check("req_addr", imem_req_addr, m_pc);
        check("valid_d", valid_d, m_ifid.v);
        check("instr_d", instr_d, m_ifid.instr);
        if (m_ifid.v) begin
          check("pc_d", pc_d, m_ifid.pc);
          check("pc_plus4_d", pc_plus4_d, m_ifid.pc + 32'd4);
        end
      end
    end
  end

  // ---------------- directed helpers (called at negedge) ----------------
  task automatic wait_hs(input logic [31:0] addr, input int bound);
    bit hit = 0;
    for (int i = 0; i < bound && !hit; i++) begin
      #3;
      if (imem_req_valid && imem_req_ready && imem_req_addr == addr) hit = 1;
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_hs: no handshake at %h within %0d cycles", addr, bound);
    end
  endtask

  task automatic wait_valid_pc(input logic [31:0] pc, input logic [31:0] pc4, input int bound);
    bit hit = 0;
    for (int i = 0; i < bound && !hit; i++) begin
      #3;
      if (valid_d && pc_d == pc) begin
        hit = 1;
        check("lit_pc_plus4", pc_plus4_d, pc4);
        check("lit_instr", instr_d, mem_word(pc));
      end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_valid_pc: pc_d never showed %h within %0d cycles", pc, bound);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n          = 1'b0;
    stall_d        = 1'b0;
    redirect_e     = 1'b0;
    redirect_pc_e  = '0;
    imem_req_ready = 1'b1;

    // Reset values.
    repeat (2) @(negedge clk);
    #3;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_valid_d", valid_d, 1'b0);
    check("rst_instr_d", instr_d, NOP);
    check("rst_pc_d", pc_d, 32'h0);
    check("rst_pc_plus4_d", pc_plus4_d, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch from 0.
    wait_valid_pc(32'h0, 32'h4, 10);

    // Cache not ready for 5 cycles while 0x8 is presented.
    imem_req_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #3;
      check("hold_req_valid", imem_req_valid, 1'b1);
      check("hold_req_addr", imem_req_addr, 32'h8);
      if (i == 0) begin
        check("lit_valid_4", valid_d, 1'b1);
        check("lit_pc_4", pc_d, 32'h4);
        check("lit_pc4_4", pc_plus4_d, 32'h8);
      end
      @(negedge clk);
    end
    imem_req_ready = 1'b1;

    // Stall while the 0xC response lands: it parks in the skid.
    @(negedge clk);
    @(negedge clk);
    stall_d = 1'b1;
    #3 check("stall_pc_8", pc_d, 32'h8);
    @(negedge clk);
    @(negedge clk);
    #3 check("stall_hold_pc", pc_d, 32'h8);
    check("stall_no_req", imem_req_valid, 1'b0);
    @(negedge clk);
    #3 check("stall_hold_pc2", pc_d, 32'h8);
    @(negedge clk);
    stall_d = 1'b0;
    #3 check("drain_no_req", imem_req_valid, 1'b0);
    @(negedge clk);
    #3 check("drain_valid", valid_d, 1'b1);
    check("drain_pc_c", pc_d, 32'hC);
    check("drain_pc4", pc_plus4_d, 32'h10);
    check("after_drain_addr", imem_req_addr, 32'h10);
    @(negedge clk);

    // Redirect while waiting on a slow 0x14 response.
    lat = 3;
    wait_hs(32'h14, 10);
    redirect_e    = 1'b1;
    redirect_pc_e = 32'h100;
    #3 check("wait_no_req", imem_req_valid, 1'b0);
    @(negedge clk);
    redirect_e = 1'b0;
    lat        = 1;
    #3 check("redir_valid_d", valid_d, 1'b0);
    check("drop_no_req", imem_req_valid, 1'b0);
    @(negedge clk);
    wait_hs(32'h100, 10);
    @(negedge clk);
    #3 check("lit_pc_100", pc_d, 32'h100);
    check("lit_pc4_100", pc_plus4_d, 32'h104);
    @(negedge clk);

    // Redirect coinciding with the 0x104 response, misaligned target.
    redirect_e    = 1'b1;
    redirect_pc_e = 32'h203;
    #3 check("samecyc_no_req", imem_req_valid, 1'b0);
    @(negedge clk);
    redirect_e = 1'b0;
    #3 check("samecyc_req", imem_req_valid, 1'b1);
    check("samecyc_addr", imem_req_addr, 32'h200);
    check("samecyc_flush", valid_d, 1'b0);
    @(negedge clk);
    wait_valid_pc(32'h200, 32'h204, 10);

    // Redirect to the top word: pc_plus4_d wraps, next fetch is 0.
    redirect_e    = 1'b1;
    redirect_pc_e = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect_e = 1'b0;
    wait_valid_pc(32'hFFFF_FFFC, 32'h0, 10);

    // Handshake, redirect and stall in one cycle while IF/ID is valid.
    lat = 3;
    @(negedge clk);
    stall_d       = 1'b1;
    redirect_e    = 1'b1;
    redirect_pc_e = 32'h300;
    #3 check("pre_flush_valid", valid_d, 1'b1);
    check("pre_flush_pc", pc_d, 32'h0);
    check("hs_redir_req", imem_req_valid, 1'b1);
    check("hs_redir_addr", imem_req_addr, 32'h4);
    @(negedge clk);
    redirect_e = 1'b0;
    #3 check("stall_flush_valid", valid_d, 1'b0);
    check("stall_flush_instr", instr_d, NOP);
    check("drop_req", imem_req_valid, 1'b0);
    @(negedge clk);
    stall_d = 1'b0;
    wait_hs(32'h300, 10);
    wait_valid_pc(32'h300, 32'h304, 10);

    @(negedge clk);
    done = 1;
    check("accepted_at_8", accepted_at_8, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time_limit: bench did not reach its summary");
    $fatal(1, "time limit");
  end

endmodule
